code_sequencer: RTL

- Transmit-side partner of the colour-code lock detector.
- On command, emits the start strobe S and then a programmable four-symbol colour press sequence on a 3-bit {red, blue, green} bus, in exactly the form the detector consumes.
- It then listens on the detector's unlock output U and reports pass/fail.
- Used as the keypad model in the system and as a stimulus engine for lock testing.

---
 rtl/code_sequencer_pkg.sv | 33 +++
 rtl/code_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/code_sequencer_pkg.sv
// Shared definitions for the colour-code sequencer: press colours, FSM states
// and the helper that pulls one 3-bit symbol out of the 12-bit code word.
package code_sequencer_pkg;

  // Colour values on the {red, blue, green} press bus; the detector uses the same ones.
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLUE  = 3'b010;
  localparam logic [2:0] GREEN = 3'b001;
  localparam logic [2:0] NONE  = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_PRESS,
    ST_GAP,
    ST_LISTEN,
    ST_REPORT
  } state_t;

  // symbol0 is the most significant field, so it is the first one sent.
  function automatic logic [2:0] code_symbol(input logic [11:0] code,
                                             input logic [1:0]  idx);
    logic [2:0] sym;
    case (idx)
      2'd0:    sym = code[11:9];
      2'd1:    sym = code[8:6];
      2'd2:    sym = code[5:3];
      default: sym = code[2:0];
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/code_sequencer.sv
// Keypad model for the colour-code lock: sends the start strobe, then four
// presses separated by GAP idle cycles, then watches U and reports pass/fail.
module code_sequencer
  import code_sequencer_pkg::*;
#(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic [11:0] Code,
  input  logic        U,
  output logic        S,
  output logic [2:0]  Out,
  output logic        Busy,
  output logic        Done,
  output logic        Pass
);

  localparam int CNT_MAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  // The counter is loaded with length-1 so that its zero cycle is the final one.
  localparam logic [CW-1:0] GAP_LOAD    = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam logic [CW-1:0] LISTEN_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t          r_state;
  logic [1:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [11:0]     r_code;
  logic            r_s;
  logic [2:0]      r_out;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;

  state_t          w_next_state;
  logic [1:0]      w_idx_next;
  logic [CW-1:0]   w_cnt_next;
  logic [11:0]     w_code_next;
  logic            w_s_next;
  logic [2:0]      w_out_next;
  logic            w_busy_next;
  logic            w_done_next;
  logic            w_pass_next;
  logic            w_last_sym;
  logic            w_cnt_zero;

  assign w_last_sym = (r_idx == 2'd3);
  assign w_cnt_zero = (r_cnt == '0);

  // State and output registers. Outputs are computed from the next state so
  // they change on the same edge as the state and reach the detector glitch-free.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (Reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      // NOTE: the latched code is reset too; it is one register, not a memory array.
      r_code  <= '0;
      r_s     <= 1'b0;
      r_out   <= NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      r_code  <= w_code_next;
      r_s     <= w_s_next;
      r_out   <= w_out_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_pass  <= w_pass_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (Go) w_next_state = ST_START;
      ST_START:  w_next_state = ST_PRESS;
      ST_PRESS: begin
        if (w_last_sym)   w_next_state = ST_LISTEN;
        else if (GAP > 0) w_next_state = ST_GAP;
        else              w_next_state = ST_PRESS;
      end
      ST_GAP:    if (w_cnt_zero) w_next_state = ST_PRESS;
      ST_LISTEN: if (U || w_cnt_zero) w_next_state = ST_REPORT;
      ST_REPORT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_idx_next  = r_idx;
    w_cnt_next  = r_cnt;
    w_code_next = r_code;
    w_pass_next = r_pass;

    case (r_state)
      ST_IDLE: begin
        if (Go) begin
          w_code_next = Code;
          w_pass_next = 1'b0;
          w_idx_next  = '0;
        end
      end
      // Advancing on the way out of Press lets Gap carry the next index.
      ST_PRESS:  if (!w_last_sym) w_idx_next = r_idx + 2'd1;
      ST_LISTEN: begin
        if (U)               w_pass_next = 1'b1;
        else if (w_cnt_zero) w_pass_next = 1'b0;
      end
      default: ;
    endcase

    // One counter serves Gap and Listen: load on entry, stop at zero.
    if (w_next_state != r_state) begin
      case (w_next_state)
        ST_GAP:    w_cnt_next = GAP_LOAD;
        ST_LISTEN: w_cnt_next = LISTEN_LOAD;
        default:   w_cnt_next = '0;
      endcase
    end else if (!w_cnt_zero) begin
      w_cnt_next = r_cnt - 1'b1;
    end

    w_s_next    = (w_next_state == ST_START);
    w_out_next  = (w_next_state == ST_PRESS) ? code_symbol(r_code, w_idx_next) : NONE;
    w_busy_next = (w_next_state != ST_IDLE);
    w_done_next = (w_next_state == ST_REPORT);
  end

  assign S    = r_s;
  assign Out  = r_out;
  assign Busy = r_busy;
  assign Done = r_done;
  assign Pass = r_pass;

endmodule
